// File: rtl/demo_audio_synth.sv
// Multi-voice audio generator: a register bank of oscillators, one mixer shared by
// all voices and swept once per sample strobe, and a first-order sigma-delta output.
module demo_audio_synth #(
    parameter int VOICES     = 4,
    parameter int PHASE_BITS = 16,
    parameter int VOL_BITS   = 4,
    parameter int VI         = (VOICES > 1) ? $clog2(VOICES) : 1,
    parameter int MIX_BITS   = 4 + VOL_BITS + $clog2(VOICES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  new_frame,
    input  logic                  voice_we,
    input  logic [VI-1:0]         voice_sel,
    input  logic [PHASE_BITS-1:0] voice_step,
    input  logic [VOL_BITS-1:0]   voice_vol,
    input  logic [1:0]            voice_wave,
    input  logic                  voice_decay,
    output logic                  audio_out,
    output logic [MIX_BITS-1:0]   sample_out,
    output logic                  busy
);

    localparam int M  = PHASE_BITS - 1;
    localparam int CW = 4 + VOL_BITS;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    logic [PHASE_BITS-1:0] phase_r [VOICES];
    logic [PHASE_BITS-1:0] step_r  [VOICES];
    logic [VOL_BITS-1:0]   vol_r   [VOICES];
    logic [1:0]            wave_r  [VOICES];
    logic [VOICES-1:0]     decay_r;

    logic [0:0]          state_r;
    logic [VI-1:0]       idx_r;
    logic [MIX_BITS-1:0] mix_r;
    logic [MIX_BITS-1:0] sample_r;
    logic [MIX_BITS-1:0] acc_r;
    logic                busy_r;
    logic                audio_r;
    logic [15:0]         lfsr_r;

    logic [VOICES-1:0]   wr_hit_s;
    logic [3:0]          wave_s;
    logic [CW-1:0]       contrib_s;
    logic                last_s;
    logic [MIX_BITS:0]   sd_sum_s;

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // top holds the five most significant phase bits.
    function automatic logic [3:0] wave_sample(input logic [1:0] wave,
                                               input logic [4:0] top,
                                               input logic [3:0] noise);
        logic [3:0] w;
        case (wave)
            2'd0:    w = top[4] ? 4'd0 : 4'd15;
            2'd1:    w = top[4:1];
            2'd2:    w = top[4] ? ~top[3:0] : top[3:0];
            2'd3:    w = noise;
            default: w = 4'd0;
        endcase
        return w;
    endfunction

    // Write decode and the contribution of the voice currently being mixed.
    always_comb begin
        wr_hit_s = '0;
        for (int v = 0; v < VOICES; v++) begin
            wr_hit_s[v] = voice_we && (voice_sel == VI'(v));
        end
        wave_s    = wave_sample(wave_r[idx_r], phase_r[idx_r][M -: 5], lfsr_r[3:0]);
        contrib_s = CW'(wave_s) * CW'(vol_r[idx_r]);
        last_s    = (idx_r == VI'(VOICES - 1));
        sd_sum_s  = {1'b0, acc_r} + {1'b0, sample_r};
    end

    // Sweep sequencer: one voice per cycle, result latched after the last voice.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            idx_r    <= '0;
            mix_r    <= '0;
            sample_r <= '0;
            busy_r   <= 1'b0;
            lfsr_r   <= 16'h0001;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        state_r <= ST_SWEEP;
                        idx_r   <= '0;
                        mix_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (last_s) begin
                        sample_r <= mix_r + MIX_BITS'(contrib_s);
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        idx_r    <= '0;
                        lfsr_r   <= lfsr_next(lfsr_r);
                    end else begin
                        mix_r <= mix_r + MIX_BITS'(contrib_s);
                        idx_r <= idx_r + VI'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Voice bank: a write overrides both the phase advance and the frame decay.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < VOICES; v++) begin
                phase_r[v] <= '0;
                step_r[v]  <= '0;
                vol_r[v]   <= '0;
                wave_r[v]  <= 2'd0;
            end
            decay_r <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (wr_hit_s[v]) begin
                    phase_r[v] <= '0;
                    step_r[v]  <= voice_step;
                    vol_r[v]   <= voice_vol;
                    wave_r[v]  <= voice_wave;
                    decay_r[v] <= voice_decay;
                end else begin
                    if ((state_r == ST_SWEEP) && (idx_r == VI'(v))) begin
                        phase_r[v] <= phase_r[v] + step_r[v];
                    end
                    if (new_frame && decay_r[v] && (vol_r[v] != '0)) begin
                        vol_r[v] <= vol_r[v] - VOL_BITS'(1);
                    end
                end
            end
        end
    end

    // First-order sigma-delta: the carry out of the accumulator is the bitstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r   <= '0;
            audio_r <= 1'b0;
        end else begin
            {audio_r, acc_r} <= sd_sum_s;
        end
    end

    assign audio_out  = audio_r;
    assign sample_out = sample_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_demo_audio_synth.sv
// Scoreboard bench for demo_audio_synth: a sweep-level reference model predicts each
// mixed sample; a monitor compares whenever busy falls.
module tb_demo_audio_synth;

    localparam int NV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       new_frame = 1'b0;
    logic       voice_we = 1'b0;
    logic [1:0] voice_sel = 2'd0;
    logic [15:0] voice_step = 16'd0;
    logic [3:0] voice_vol = 4'd0;
    logic [1:0] voice_wave = 2'd0;
    logic       voice_decay = 1'b0;
    logic       audio_out;
    logic [9:0] sample_out;
    logic       busy;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    int m_phase[NV];
    int m_step[NV];
    int m_vol[NV];
    int m_wave[NV];
    int m_dec[NV];
    int m_lfsr;
    int m_last;

    demo_audio_synth dut (
        .clk(clk), .reset(reset), .enable(enable), .new_frame(new_frame),
        .voice_we(voice_we), .voice_sel(voice_sel), .voice_step(voice_step),
        .voice_vol(voice_vol), .voice_wave(voice_wave), .voice_decay(voice_decay),
        .audio_out(audio_out), .sample_out(sample_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one whole sweep at a time) ----------------
    function automatic int m_wave_val(input int wave, input int ph, input int lf);
        case (wave)
            0:       return (ph < 32768) ? 15 : 0;
            1:       return ph / 4096;
            2:       return (ph < 32768) ? (ph / 2048) % 16 : 15 - ((ph / 2048) % 16);
            default: return lf % 16;
        endcase
    endfunction

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = 0; m_step[v] = 0; m_vol[v] = 0; m_wave[v] = 0; m_dec[v] = 0;
        end
        m_lfsr = 1;
        m_last = 0;
        exp_q.delete();
    endtask

    task automatic m_sweep();
        int s = 0;
        int fb;
        for (int v = 0; v < NV; v++) begin
            s += m_wave_val(m_wave[v], m_phase[v], m_lfsr) * m_vol[v];
            m_phase[v] = (m_phase[v] + m_step[v]) % 65536;
        end
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
        m_lfsr = ((m_lfsr * 2) + fb) % 65536;
        m_last = s;
        exp_q.push_back(s);
    endtask

    task automatic m_decay();
        for (int v = 0; v < NV; v++)
            if (m_dec[v] == 1 && m_vol[v] > 0) m_vol[v] = m_vol[v] - 1;
    endtask

    task automatic m_write(input int sel, input int step, input int vol, input int wave, input int dec);
        m_phase[sel] = 0; m_step[sel] = step; m_vol[sel] = vol;
        m_wave[sel] = wave; m_dec[sel] = dec;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input int sel, input int step, input int vol, input int wave, input int dec);
        voice_we = 1'b1;
        voice_sel = 2'(sel);
        voice_step = 16'(step);
        voice_vol = 4'(vol);
        voice_wave = 2'(wave);
        voice_decay = 1'(dec);
    endtask

    task automatic wr(input int sel, input int step, input int vol, input int wave, input int dec, input int nf);
        drive_write(sel, step, vol, wave, dec);
        new_frame = 1'(nf);
        if (nf != 0) m_decay();
        m_write(sel, step, vol, wave, dec);
        tick();
        voice_we = 1'b0;
        new_frame = 1'b0;
    endtask

    task automatic frame();
        new_frame = 1'b1;
        m_decay();
        tick();
        new_frame = 1'b0;
    endtask

    // Issues one sweep and returns in the middle of the cycle where the result shows.
    task automatic start();
        enable = 1'b1;
        m_sweep();
        tick();
        enable = 1'b0;
        repeat (4) tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        m_reset();
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic busy_q = 1'b0;
        logic rst_q = 1'b1;
        forever begin
            @(negedge clk);
            if (busy_q === 1'b1 && busy === 1'b0 && rst_q === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", int'(sample_out), -1);
                end else begin
                    check("sample_scoreboard", int'(sample_out), exp_q.pop_front());
                end
            end
            busy_q = busy;
            rst_q = reset;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin : stim
        int ones;
        int cnt;
        int sq_exp[4] = '{225, 0, 225, 0};
        int dc_exp[4] = '{30, 15, 0, 0};
        int nz_exp[4] = '{1, 2, 4, 8};
        int op;

        m_reset();
        do_reset(3);
        @(negedge clk);
        check("reset_audio", int'(audio_out), 0);
        check("reset_sample", int'(sample_out), 0);
        check("reset_busy", int'(busy), 0);

        // Reset in the middle of a sweep with a loud voice active.
        wr(0, 0, 15, 0, 0, 0);
        start();
        check("pre_reset_sample", int'(sample_out), 225);
        enable = 1'b1;
        m_sweep();
        tick();
        enable = 1'b0;
        tick();
        do_reset(3);
        @(negedge clk);
        check("midsweep_reset_busy", int'(busy), 0);
        check("midsweep_reset_sample", int'(sample_out), 0);
        check("midsweep_reset_audio", int'(audio_out), 0);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            ones += int'(audio_out);
        end
        check("idle_audio_ones", ones, 0);

        // Latency and overrun: second enable during the sweep is dropped.
        wr(0, 0, 15, 0, 0, 0);
        enable = 1'b1;
        m_sweep();
        tick();
        for (int k = 1; k <= 4; k++) begin
            enable = (k == 2);
            @(negedge clk);
            check("latency_busy_high", int'(busy), 1);
            tick();
        end
        enable = 1'b0;
        @(negedge clk);
        check("latency_busy_low", int'(busy), 0);
        check("latency_sample", int'(sample_out), 225);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(busy);
        end
        check("overrun_no_second_sweep", cnt, 0);

        // Square toggle at half-rate step.
        wr(0, 16'h8000, 15, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            start();
            check("square_toggle", int'(sample_out), sq_exp[i]);
        end

        // Sigma-delta ones density.
        wr(0, 0, 15, 0, 0, 0);
        wr(1, 0, 15, 0, 0, 0);
        start();
        check("density_sample", int'(sample_out), 450);
        repeat (20) @(negedge clk);
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            ones += int'(audio_out);
        end
        check("density_ones", ones, 450);

        // Per-frame decay, then a write coinciding with new_frame.
        wr(1, 0, 0, 0, 0, 0);
        wr(0, 0, 3, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            frame();
            start();
            check("decay_sample", int'(sample_out), dc_exp[i]);
        end
        wr(0, 0, 7, 0, 1, 1);
        start();
        check("write_beats_decay", int'(sample_out), 105);

        // Noise from a freshly reset LFSR.
        do_reset(2);
        wr(0, 0, 1, 3, 0, 0);
        for (int i = 0; i < 12; i++) begin
            start();
            if (i < 4) check("noise_seq", int'(sample_out), nz_exp[i]);
        end

        // Saw ramp with wrap.
        wr(0, 0, 0, 0, 0, 0);
        wr(1, 16'h1000, 1, 1, 0, 0);
        for (int i = 0; i < 18; i++) begin
            start();
            check("saw_ramp", int'(sample_out), i % 16);
        end

        // Write to the voice being processed in that very cycle.
        wr(1, 0, 0, 0, 0, 0);
        wr(2, 16'h1000, 15, 1, 0, 0);
        start();
        start();
        enable = 1'b1;
        m_sweep();
        tick();
        enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) begin
                drive_write(2, 16'h3000, 15, 1, 0);
                m_write(2, 16'h3000, 15, 1, 0);
            end else begin
                voice_we = 1'b0;
            end
            tick();
        end
        voice_we = 1'b0;
        @(negedge clk);
        start();
        check("collision_phase_zero", int'(sample_out), 0);
        start();
        check("collision_new_step", int'(sample_out), 45);

        // Randomized mix of writes, frames and sweeps.
        wr(3, 16'h0800, 15, 2, 0, 0);
        for (int i = 0; i < 120; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                wr($urandom_range(0, 3), $urandom_range(0, 65535), $urandom_range(0, 15),
                   $urandom_range(0, 3), $urandom_range(0, 1), 0);
            end else if (op == 4) begin
                frame();
            end else if (op <= 8) begin
                start();
            end else begin
                tick();
            end
        end

        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
